// File: rtl/display_pkg.sv
// Shared display definitions: scan FSM states, blank pattern and the 0..9
// seven-segment patterns ({g,f,e,d,c,b,a}, active-high) used by every display stage.
package display_pkg;

  typedef enum logic [1:0] {
    S_BLANK_U = 2'd0,
    S_UNI     = 2'd1,
    S_BLANK_D = 2'd2,
    S_DEC     = 2'd3
  } state_t;

  localparam logic [6:0] SEG_OFF   = 7'b0000000;
  localparam logic [6:0] SEG_DIG_0 = 7'b0111111;
  localparam logic [6:0] SEG_DIG_1 = 7'b0000110;
  localparam logic [6:0] SEG_DIG_2 = 7'b1011011;
  localparam logic [6:0] SEG_DIG_3 = 7'b1001111;
  localparam logic [6:0] SEG_DIG_4 = 7'b1100110;
  localparam logic [6:0] SEG_DIG_5 = 7'b1101101;
  localparam logic [6:0] SEG_DIG_6 = 7'b1111101;
  localparam logic [6:0] SEG_DIG_7 = 7'b0000111;
  localparam logic [6:0] SEG_DIG_8 = 7'b1111111;
  localparam logic [6:0] SEG_DIG_9 = 7'b1100111;

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD digit to seven-segment decoder; codes 10..15 are blanked.
module seg7_dec
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_OFF;
    case (digit)
      4'd0: pattern = SEG_DIG_0;
      4'd1: pattern = SEG_DIG_1;
      4'd2: pattern = SEG_DIG_2;
      4'd3: pattern = SEG_DIG_3;
      4'd4: pattern = SEG_DIG_4;
      4'd5: pattern = SEG_DIG_5;
      4'd6: pattern = SEG_DIG_6;
      4'd7: pattern = SEG_DIG_7;
      4'd8: pattern = SEG_DIG_8;
      4'd9: pattern = SEG_DIG_9;
      default: pattern = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_mux_2dig.sv
// Two-digit multiplexed 7-segment driver showing 0..15 as "00".."15", one snapshot per frame.
// Optional macro LEADING_ZERO_BLANK_EN blanks a tens digit of zero.
module display_mux_2dig
  import display_pkg::*;
#(
  parameter int SCAN_DIV         = 50000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] valor,
  output logic [6:0] segmentos,
  output logic [1:0] anodos,
  output logic       frame_tick
);

  localparam int             PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [1:0]     AN_OFF   = ANODE_ACTIVE_LOW ? 2'b11 : 2'b00;
  localparam logic [1:0]     AN_UNI   = ANODE_ACTIVE_LOW ? 2'b10 : 2'b01;
  localparam logic [1:0]     AN_DEC   = ANODE_ACTIVE_LOW ? 2'b01 : 2'b10;

  state_t        state_reg, state_next;
  logic [PW-1:0] pre_reg, pre_next;
  logic [3:0]    snap_reg, snap_next;
  logic          run_reg;
  logic [6:0]    seg_reg, seg_next;
  logic [1:0]    an_reg, an_next;
  logic          tick_reg, tick_next;

  logic          tens;
  logic [3:0]    units;
  logic [3:0]    digit;
  logic [6:0]    pattern;

  // run_reg holds the FSM in S_BLANK_U for one extra cycle after reset so the
  // first post-reset frame still opens with a visible frame_tick.
  always_comb begin
    state_next = state_reg;
    pre_next   = pre_reg;
    snap_next  = snap_reg;
    unique case (state_reg)
      S_BLANK_U: begin
        pre_next = '0;
        if (run_reg) begin
          state_next = S_UNI;
          snap_next  = valor;
        end
      end
      S_UNI: begin
        if (pre_reg == PRE_LAST) begin
          state_next = S_BLANK_D;
          pre_next   = '0;
        end else begin
          pre_next = pre_reg + PW'(1);
        end
      end
      S_BLANK_D: begin
        state_next = S_DEC;
        pre_next   = '0;
      end
      S_DEC: begin
        if (pre_reg == PRE_LAST) begin
          state_next = S_BLANK_U;
          pre_next   = '0;
        end else begin
          pre_next = pre_reg + PW'(1);
        end
      end
      default: begin
        state_next = S_BLANK_U;
        pre_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and next snapshot so they register
  // on the same edge the phase is entered.
  assign tens  = (snap_next >= 4'd10);
  assign units = tens ? (snap_next - 4'd10) : snap_next;
  assign digit = (state_next == S_DEC) ? {3'b000, tens} : units;

  seg7_dec u_dec (
    .digit   (digit),
    .pattern (pattern)
  );

  always_comb begin
    seg_next  = SEG_OFF;
    an_next   = AN_OFF;
    tick_next = 1'b0;
    unique case (state_next)
      S_BLANK_U: tick_next = 1'b1;
      S_UNI: begin
        an_next  = AN_UNI;
        seg_next = pattern;
      end
      S_DEC: begin
        an_next = AN_DEC;
`ifdef LEADING_ZERO_BLANK_EN
        seg_next = tens ? pattern : SEG_OFF;
`else
        seg_next = pattern;
`endif
      end
      default: begin
        seg_next = SEG_OFF;
        an_next  = AN_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_BLANK_U;
      pre_reg   <= '0;
      snap_reg  <= '0;
      run_reg   <= 1'b0;
      seg_reg   <= SEG_OFF;
      an_reg    <= AN_OFF;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pre_reg   <= pre_next;
      snap_reg  <= snap_next;
      run_reg   <= 1'b1;
      seg_reg   <= seg_next;
      an_reg    <= an_next;
      tick_reg  <= tick_next;
    end
  end

  assign segmentos  = seg_reg;
  assign anodos     = an_reg;
  assign frame_tick = tick_reg;

endmodule

// File: tb/tb_display_mux_2dig.sv
// Bench for display_mux_2dig: two instances (SCAN_DIV=4 active-low, SCAN_DIV=1 active-high)
// compared every cycle against a frame-position reference model.
module tb_display_mux_2dig;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] valor;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic       tick_a, tick_b;

  int errors = 0;
  int checks = 0;

  int         k_a, k_b;
  logic [3:0] snap_a, snap_b;
  logic [3:0] sweep_val;

  localparam int N_A = 4;
  localparam int N_B = 1;

  always #5 clk = ~clk;

  display_mux_2dig #(.SCAN_DIV(N_A), .ANODE_ACTIVE_LOW(1'b1)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .valor      (valor),
    .segmentos  (seg_a),
    .anodos     (an_a),
    .frame_tick (tick_a)
  );

  display_mux_2dig #(.SCAN_DIV(N_B), .ANODE_ACTIVE_LOW(1'b0)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .valor      (valor),
    .segmentos  (seg_b),
    .anodos     (an_b),
    .frame_tick (tick_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1100111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Returns {frame_tick, anodos, segmentos} for position k of a frame of length 2n+2.
  function automatic logic [9:0] model(input int k, input int n, input logic [3:0] snap, input bit alow);
    int t;
    int u;
    logic [1:0] off;
    logic [1:0] on_u;
    logic [1:0] on_d;
    logic [6:0] seg_t;
    t    = int'(snap) / 10;
    u    = int'(snap) % 10;
    off  = alow ? 2'b11 : 2'b00;
    on_u = alow ? 2'b10 : 2'b01;
    on_d = alow ? 2'b01 : 2'b10;
    seg_t = pat(t);
`ifdef LEADING_ZERO_BLANK_EN
    if (t == 0) seg_t = 7'b0000000;
`endif
    if (k == 0)          return {1'b1, off, 7'b0000000};
    else if (k <= n)     return {1'b0, on_u, pat(u)};
    else if (k == n + 1) return {1'b0, off, 7'b0000000};
    else                 return {1'b0, on_d, seg_t};
  endfunction

  // mode: 0 hold, 1 set v, 2 random change, 3 set v only in tens phase of dut_a, 4 sweep per frame
  task automatic cycle(input int mode, input logic [3:0] v);
    logic [9:0] ea;
    logic [9:0] eb;
    @(negedge clk);
    ea = model(k_a, N_A, snap_a, 1'b1);
    eb = model(k_b, N_B, snap_b, 1'b0);
    check_val("a_seg",  {25'd0, seg_a},  {25'd0, ea[6:0]});
    check_val("a_an",   {30'd0, an_a},   {30'd0, ea[8:7]});
    check_val("a_tick", {31'd0, tick_a}, {31'd0, ea[9]});
    check_val("b_seg",  {25'd0, seg_b},  {25'd0, eb[6:0]});
    check_val("b_an",   {30'd0, an_b},   {30'd0, eb[8:7]});
    check_val("b_tick", {31'd0, tick_b}, {31'd0, eb[9]});
    case (mode)
      1: valor = v;
      2: if ($urandom_range(0, 4) == 0) valor = 4'($urandom_range(0, 15));
      3: if (k_a == 2 * N_A) valor = v;
      4: if (k_a == 0) begin
           valor = sweep_val;
           sweep_val = sweep_val + 4'd1;
         end
      default: ;
    endcase
    if (k_a == 0) begin
      snap_a = valor;
      $display("frame start: valor=%0d shown next by dut_a", valor);
    end
    if (k_b == 0) snap_b = valor;
    k_a = (k_a + 1) % (2 * N_A + 2);
    k_b = (k_b + 1) % (2 * N_B + 2);
  endtask

  // Asserts reset between clock edges and checks the asynchronous response.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check_val("rst_a_an",   {30'd0, an_a},   32'd3);
    check_val("rst_a_seg",  {25'd0, seg_a},  32'd0);
    check_val("rst_a_tick", {31'd0, tick_a}, 32'd0);
    check_val("rst_b_an",   {30'd0, an_b},   32'd0);
    @(negedge clk);
    check_val("rst_hold_a_an",   {30'd0, an_a},   32'd3);
    check_val("rst_hold_a_tick", {31'd0, tick_a}, 32'd0);
    reset = 1'b0;
    k_a = 0;
    k_b = 0;
  endtask

  initial begin
    reset     = 1'b0;
    valor     = 4'd7;
    k_a       = 0;
    k_b       = 0;
    snap_a    = 4'd0;
    snap_b    = 4'd0;
    sweep_val = 4'd0;
    @(negedge clk);
    do_reset();
    repeat (20) cycle(0, 4'd0);
    cycle(1, 4'd13);
    repeat (19) cycle(0, 4'd0);
    cycle(1, 4'd5);
    repeat (19) cycle(0, 4'd0);
    repeat (10) cycle(3, 4'd12);
    repeat (20) cycle(0, 4'd0);
    for (int i = 0; i < 20 && k_a != 3; i++) cycle(0, 4'd0);
    do_reset();
    repeat (20) cycle(0, 4'd0);
    repeat (17 * (2 * N_A + 2)) cycle(4, 4'd0);
    repeat (400) cycle(2, 4'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
